// File: rtl/ahbl_trace_buffer_pkg.sv
// Shared encodings and record layout for the AHB-Lite transfer tracer.
package ahbl_trace_pkg;

   // AHB-Lite HTRANS encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // AHB-Lite HSIZE encodings
   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HALF  = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;

   // Capture FSM states
   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_ARMED   = 2'b01;
   localparam logic [1:0] ST_STOPPED = 2'b10;

   localparam int W_SIZE = 3;

   // Record layout, LSB first: addr | data | size | write | err
   function automatic int rec_width(input int w_addr, input int w_data);
      return w_addr + w_data + W_SIZE + 2;
   endfunction

   function automatic int rec_off_size(input int w_addr, input int w_data);
      return w_addr + w_data;
   endfunction

   function automatic int rec_off_write(input int w_addr, input int w_data);
      return w_addr + w_data + W_SIZE;
   endfunction

   function automatic int rec_off_err(input int w_addr, input int w_data);
      return w_addr + w_data + W_SIZE + 1;
   endfunction

endpackage

// File: rtl/ahbl_trace_buffer_if.sv
// AHB-Lite bus bundle; the tracer attaches through the passive monitor view.
interface ahbl_trace_buffer_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);
   logic [W_ADDR-1:0] haddr;
   logic [1:0]        htrans;
   logic              hwrite;
   logic [2:0]        hsize;
   logic              hready;
   logic              hresp;
   logic [W_DATA-1:0] hwdata;
   logic [W_DATA-1:0] hrdata;

   modport master (
      output haddr, htrans, hwrite, hsize, hwdata,
      input  hready, hresp, hrdata
   );

   modport slave (
      input  haddr, htrans, hwrite, hsize, hwdata,
      output hready, hresp, hrdata
   );

   modport monitor (
      input haddr, htrans, hwrite, hsize, hready, hresp, hwdata, hrdata
   );
endinterface

// File: rtl/ahbl_trace_buffer_mem.sv
// Circular record store: pop is taken before push, full pushes either
// overwrite the oldest record or are dropped, and clear flushes everything.
module ahbl_trace_mem #(
   parameter int DEPTH = 64,
   parameter int W_REC = 69,
   parameter int W_CNT = $clog2(DEPTH) + 1
) (
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             overwrite,
   input  logic             push,
   input  logic [W_REC-1:0] push_rec,
   input  logic             pop,
   output logic [W_REC-1:0] rd_rec,
   output logic [W_CNT-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             lost
);
   localparam int W_PTR = $clog2(DEPTH);

   logic [W_REC-1:0] mem_r [DEPTH];
   logic [W_PTR-1:0] wptr_r;
   logic [W_PTR-1:0] rptr_r;
   logic [W_CNT-1:0] count_r;
   logic [W_CNT-1:0] count_nxt_s;
   logic             pop_take_s;
   logic             wr_en_s;
   logic             rd_adv_s;
   logic             full_s;
   logic             empty_s;

   // Decide this cycle's write, read-advance and occupancy change
   always_comb begin
      full_s     = (count_r == W_CNT'(DEPTH));
      empty_s    = (count_r == {W_CNT{1'b0}});
      pop_take_s = pop && !empty_s && !clear;
      wr_en_s    = push && !clear && (!full_s || pop_take_s || overwrite);
      lost       = push && !clear && full_s && !pop_take_s;
      rd_adv_s   = pop_take_s || (wr_en_s && full_s);
      if (wr_en_s && !full_s && !pop_take_s) begin
         count_nxt_s = count_r + W_CNT'(1'b1);
      end else if (pop_take_s && !wr_en_s) begin
         count_nxt_s = count_r - W_CNT'(1'b1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r  <= {W_PTR{1'b0}};
         rptr_r  <= {W_PTR{1'b0}};
         count_r <= {W_CNT{1'b0}};
      end else if (clear) begin
         wptr_r  <= {W_PTR{1'b0}};
         rptr_r  <= {W_PTR{1'b0}};
         count_r <= {W_CNT{1'b0}};
      end else begin
         if (wr_en_s) begin
            wptr_r <= wptr_r + W_PTR'(1'b1);
         end
         if (rd_adv_s) begin
            rptr_r <= rptr_r + W_PTR'(1'b1);
         end
         count_r <= count_nxt_s;
      end
   end

   // Record storage; contents are don't-care until written
   always_ff @(posedge clk_sys) begin
      if (wr_en_s) begin
         mem_r[wptr_r] <= push_rec;
      end
   end

   // Head record, forced to zero when nothing is held
   always_comb begin
      rd_rec = empty_s ? {W_REC{1'b0}} : mem_r[rptr_r];
      count  = count_r;
      full   = full_s;
      empty  = empty_s;
   end

endmodule

// File: rtl/ahbl_trace_buffer.sv
// AHB-Lite transfer tracer: snoops one master port, filters completed
// transfers by window and direction, and queues one record per transfer.
module ahbl_trace_buffer
   import ahbl_trace_pkg::*;
#(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32,
   parameter int DEPTH  = 64,
   parameter int W_CNT  = $clog2(DEPTH) + 1
) (
   input  logic                  clk_sys,
   input  logic                  rst_n,
   ahbl_trace_buffer_if.monitor  ahb,
   input  logic                  arm,
   input  logic                  clear,
   input  logic                  mode_stop,
   input  logic                  cap_r,
   input  logic                  cap_w,
   input  logic [W_ADDR-1:0]     win_base,
   input  logic [W_ADDR-1:0]     win_mask,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [W_ADDR-1:0]     rd_addr,
   output logic [W_DATA-1:0]     rd_data,
   output logic                  rd_write,
   output logic                  rd_err,
   output logic [2:0]            rd_size,
   output logic [W_CNT-1:0]      count,
   output logic                  overflow,
   output logic                  stopped
);
   localparam int W_REC  = rec_width(W_ADDR, W_DATA);
   localparam int O_SIZE = rec_off_size(W_ADDR, W_DATA);
   localparam int O_WR   = rec_off_write(W_ADDR, W_DATA);
   localparam int O_ERR  = rec_off_err(W_ADDR, W_DATA);

   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   logic              dph_act_r;
   logic [W_ADDR-1:0] dph_addr_r;
   logic [2:0]        dph_size_r;
   logic              dph_write_r;
   logic              overflow_r;
   logic              qual_s;
   logic              push_s;
   logic              pop_s;
   logic              fill_s;
   logic              lost_s;
   logic              full_s;
   logic              empty_s;
   logic [W_DATA-1:0] rec_data_s;
   logic [W_REC-1:0]  rec_in_s;
   logic [W_REC-1:0]  rec_out_s;
   logic [W_CNT-1:0]  count_s;

   // Address-phase qualification and data-phase record assembly
   always_comb begin
      qual_s = ((ahb.htrans == HTRANS_NONSEQ) || (ahb.htrans == HTRANS_SEQ))
               && (state_r == ST_ARMED)
               && (ahb.hwrite ? cap_w : cap_r)
               && (((ahb.haddr ^ win_base) & win_mask) == {W_ADDR{1'b0}});
      push_s = dph_act_r && ahb.hready && !clear;
      pop_s  = rd_ready && !empty_s;
      fill_s = push_s && !pop_s && (count_s == W_CNT'(DEPTH - 1));
      if (ahb.hresp) begin
         rec_data_s = {W_DATA{1'b0}};
      end else begin
         rec_data_s = dph_write_r ? ahb.hwdata : ahb.hrdata;
      end
      rec_in_s = {ahb.hresp, dph_write_r, dph_size_r, rec_data_s, dph_addr_r};
   end

   // Hold the qualified address phase until its data phase completes
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         dph_act_r   <= 1'b0;
         dph_addr_r  <= {W_ADDR{1'b0}};
         dph_size_r  <= 3'b000;
         dph_write_r <= 1'b0;
      end else if (clear) begin
         dph_act_r   <= 1'b0;
      end else if (ahb.hready) begin
         dph_act_r   <= qual_s;
         dph_addr_r  <= ahb.haddr;
         dph_size_r  <= ahb.hsize;
         dph_write_r <= ahb.hwrite;
      end
   end

   // Capture FSM next state; filling the buffer in stop mode halts capture
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (arm) state_nxt_s = ST_ARMED;
            else     state_nxt_s = ST_IDLE;
         end
         ST_ARMED: begin
            if (!arm)                             state_nxt_s = ST_IDLE;
            else if (mode_stop && (full_s || fill_s)) state_nxt_s = ST_STOPPED;
            else                                  state_nxt_s = ST_ARMED;
         end
         ST_STOPPED: begin
            if (!arm) state_nxt_s = ST_IDLE;
            else      state_nxt_s = ST_STOPPED;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Capture FSM state register
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_nxt_s;
   end

   // Sticky loss flag, cleared only by clear or reset
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n)      overflow_r <= 1'b0;
      else if (clear)  overflow_r <= 1'b0;
      else if (lost_s) overflow_r <= 1'b1;
   end

   ahbl_trace_mem #(
      .DEPTH (DEPTH),
      .W_REC (W_REC),
      .W_CNT (W_CNT)
   ) u_mem (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .clear     (clear),
      .overwrite (!mode_stop),
      .push      (push_s),
      .push_rec  (rec_in_s),
      .pop       (pop_s),
      .rd_rec    (rec_out_s),
      .count     (count_s),
      .full      (full_s),
      .empty     (empty_s),
      .lost      (lost_s)
   );

   // Readout fields straight from the head record
   always_comb begin
      rd_valid = !empty_s;
      rd_addr  = rec_out_s[W_ADDR-1:0];
      rd_data  = rec_out_s[O_SIZE-1:W_ADDR];
      rd_size  = rec_out_s[O_WR-1:O_SIZE];
      rd_write = rec_out_s[O_WR];
      rd_err   = rec_out_s[O_ERR];
      count    = count_s;
      overflow = overflow_r;
      stopped  = (state_r == ST_STOPPED);
   end

endmodule

// File: tb/tb_ahbl_trace_buffer.sv
// Randomized and directed bench for ahbl_trace_buffer against a queue model.
module tb_ahbl_trace_buffer;
   import ahbl_trace_pkg::*;

   localparam int W_ADDR = 32;
   localparam int W_DATA = 32;
   localparam int DEPTH  = 4;
   localparam int W_CNT  = 3;
   localparam int MAXT   = 8;

   logic        clk_sys = 1'b0;
   logic        rst_n, arm, clear, mode_stop, cap_r, cap_w, rd_ready;
   logic [31:0] win_base, win_mask;
   logic        rd_valid, rd_write, rd_err, overflow, stopped;
   logic [31:0] rd_addr, rd_data;
   logic [2:0]  rd_size;
   logic [W_CNT-1:0] count;

   ahbl_trace_buffer_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) ahb ();

   always #5 clk_sys = ~clk_sys;

   ahbl_trace_buffer #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .DEPTH(DEPTH), .W_CNT(W_CNT)) dut (
      .clk_sys(clk_sys), .rst_n(rst_n), .ahb(ahb), .arm(arm), .clear(clear),
      .mode_stop(mode_stop), .cap_r(cap_r), .cap_w(cap_w), .win_base(win_base),
      .win_mask(win_mask), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_write(rd_write), .rd_err(rd_err), .rd_size(rd_size),
      .count(count), .overflow(overflow), .stopped(stopped)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        wr;
      logic        err;
      logic [2:0]  sz;
   } rec_t;
   typedef enum {M_IDLE, M_ARMED, M_STOPPED} mstate_t;

   rec_t        mq[$];
   mstate_t     m_state;
   bit          m_pend, m_ovf;
   logic [31:0] m_paddr;
   logic        m_pwr;
   logic [2:0]  m_psz;

   int n_checks = 0;
   int n_pass   = 0;

   // transfer table for the bus driver
   logic [31:0] t_addr [MAXT];
   logic [31:0] t_data [MAXT];
   logic        t_wr   [MAXT];
   logic [2:0]  t_sz   [MAXT];
   logic [1:0]  t_tr   [MAXT];
   int          t_waits[MAXT];
   logic        t_err  [MAXT];
   logic        t_rdy  [MAXT];
   logic        t_clr  [MAXT];
   bit          rand_rdy = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      m_pend  = 1'b0;
      m_ovf   = 1'b0;
      m_state = M_IDLE;
   endtask

   // Advance the model by one clock edge using the inputs currently driven
   task automatic model_step();
      int   pre;
      rec_t r;
      if (!rst_n) begin
         model_reset();
         return;
      end
      pre = mq.size();
      if (clear) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_pend = 1'b0;
      end else begin
         if (rd_ready && mq.size() != 0) void'(mq.pop_front());
         if (ahb.hready) begin
            if (m_pend) begin
               r.addr = m_paddr;
               r.wr   = m_pwr;
               r.sz   = m_psz;
               r.err  = ahb.hresp;
               r.data = ahb.hresp ? 32'h0 : (m_pwr ? ahb.hwdata : ahb.hrdata);
               if (mq.size() < DEPTH) begin
                  mq.push_back(r);
               end else if (!mode_stop) begin
                  void'(mq.pop_front());
                  mq.push_back(r);
                  m_ovf = 1'b1;
               end else begin
                  m_ovf = 1'b1;
               end
            end
            m_pend  = ahb.htrans[1] && (m_state == M_ARMED) && (ahb.hwrite ? cap_w : cap_r)
                      && (((ahb.haddr ^ win_base) & win_mask) == 32'h0);
            m_paddr = ahb.haddr;
            m_pwr   = ahb.hwrite;
            m_psz   = ahb.hsize;
         end
      end
      case (m_state)
         M_IDLE:  if (arm) m_state = M_ARMED;
         M_ARMED: begin
            if (!arm) m_state = M_IDLE;
            else if (mode_stop && (pre == DEPTH || mq.size() == DEPTH)) m_state = M_STOPPED;
         end
         default: if (!arm) m_state = M_IDLE;
      endcase
   endtask

   task automatic compare_all();
      check_eq("count", 64'(count), 64'(mq.size()));
      check_eq("rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
      check_eq("overflow", 64'(overflow), 64'(m_ovf));
      check_eq("stopped", 64'(stopped), 64'(m_state == M_STOPPED));
      if (mq.size() != 0) begin
         check_eq("rd_addr", 64'(rd_addr), 64'(mq[0].addr));
         check_eq("rd_data", 64'(rd_data), 64'(mq[0].data));
         check_eq("rd_write", 64'(rd_write), 64'(mq[0].wr));
         check_eq("rd_err", 64'(rd_err), 64'(mq[0].err));
         check_eq("rd_size", 64'(rd_size), 64'(mq[0].sz));
      end else begin
         check_eq("rd_addr_empty", 64'(rd_addr), 64'h0);
         check_eq("rd_data_empty", 64'(rd_data), 64'h0);
         check_eq("rd_flags_empty", 64'({rd_write, rd_err, rd_size}), 64'h0);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_sys);
      #1;
      compare_all();
   endtask

   function automatic logic pick_rdy(input logic d);
      return rand_rdy ? 1'($urandom_range(0, 1)) : d;
   endfunction

   task automatic drive_addr(input int i, input int n);
      if (i < n) begin
         ahb.htrans = t_tr[i];
         ahb.haddr  = t_addr[i];
         ahb.hwrite = t_wr[i];
         ahb.hsize  = t_sz[i];
      end else begin
         ahb.htrans = HTRANS_IDLE;
         ahb.haddr  = 32'h0;
         ahb.hwrite = 1'b0;
         ahb.hsize  = 3'b000;
      end
   endtask

   task automatic set_t(input int i, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input int waits, input logic e);
      t_addr[i] = a; t_wr[i] = w; t_data[i] = d; t_waits[i] = waits; t_err[i] = e;
      t_sz[i] = HSIZE_WORD; t_tr[i] = HTRANS_NONSEQ; t_rdy[i] = 1'b0; t_clr[i] = 1'b0;
   endtask

   // Pipelined AHB-Lite driver for transfers 0..n-1 of the table
   task automatic run(input int n);
      ahb.hready = 1'b1; ahb.hresp = 1'b0; clear = 1'b0;
      drive_addr(0, n);
      rd_ready = pick_rdy(1'b0);
      tick();
      for (int i = 0; i < n; i++) begin
         drive_addr(i + 1, n);
         ahb.hwdata = t_wr[i] ? t_data[i] : $urandom();
         ahb.hrdata = t_wr[i] ? $urandom() : t_data[i];
         ahb.hresp  = t_err[i];
         for (int w = 0; w < t_waits[i]; w++) begin
            ahb.hready = 1'b0; clear = 1'b0;
            rd_ready = pick_rdy(1'b0);
            tick();
         end
         ahb.hready = 1'b1; clear = t_clr[i];
         rd_ready = pick_rdy(t_rdy[i]);
         tick();
      end
      ahb.htrans = HTRANS_IDLE; ahb.hresp = 1'b0; clear = 1'b0; rd_ready = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      logic [31:0] top;
      int          n;
      rst_n = 1'b0; arm = 1'b0; clear = 1'b0; mode_stop = 1'b0;
      cap_r = 1'b1; cap_w = 1'b1; win_base = 32'h0; win_mask = 32'h0; rd_ready = 1'b0;
      ahb.haddr = 32'h0; ahb.htrans = HTRANS_IDLE; ahb.hwrite = 1'b0; ahb.hsize = 3'b000;
      ahb.hready = 1'b1; ahb.hresp = 1'b0; ahb.hwdata = 32'h0; ahb.hrdata = 32'h0;
      model_reset();
      tick();
      tick();
      check_eq("reset_count", 64'(count), 64'h0);
      check_eq("reset_flags", 64'({rd_valid, overflow, stopped}), 64'h0);
      rst_n = 1'b1;

      // basic write then read with two wait states
      arm = 1'b1;
      tick();
      set_t(0, 32'h2000_0004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
      set_t(1, 32'h2000_0008, 1'b0, 32'h1234_5678, 2, 1'b0);
      run(2);
      check_eq("basic_count", 64'(count), 64'h2);
      check_eq("basic_addr0", 64'(rd_addr), 64'h2000_0004);
      check_eq("basic_data0", 64'(rd_data), 64'hDEAD_BEEF);
      check_eq("basic_size0", 64'(rd_size), 64'h2);
      check_eq("basic_wr_err0", 64'({rd_write, rd_err}), 64'h2);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      check_eq("basic_addr1", 64'(rd_addr), 64'h2000_0008);
      check_eq("basic_data1", 64'(rd_data), 64'h1234_5678);
      check_eq("basic_wr_err1", 64'({rd_write, rd_err}), 64'h0);
      pulse_clear();

      // address window and direction filter
      win_base = 32'h4000_0000; win_mask = 32'hF000_0000;
      set_t(0, 32'h4000_0010, 1'b1, 32'h0000_00A1, 0, 1'b0);
      set_t(1, 32'h2000_0000, 1'b1, 32'h0000_00A2, 0, 1'b0);
      run(2);
      check_eq("win_count", 64'(count), 64'h1);
      check_eq("win_addr", 64'(rd_addr), 64'h4000_0010);
      cap_r = 1'b0;
      set_t(0, 32'h4000_0020, 1'b0, 32'h0000_00A3, 1, 1'b0);
      run(1);
      check_eq("capr_count", 64'(count), 64'h1);
      cap_r = 1'b1; win_base = 32'h0; win_mask = 32'h0;
      pulse_clear();

      // wrap mode: six pushes into four slots
      for (int i = 0; i < 6; i++) set_t(i, 32'h1000 + 32'(4 * (i + 1)), 1'b1, 32'hA0 + 32'(i), 0, 1'b0);
      run(6);
      check_eq("wrap_count", 64'(count), 64'h4);
      check_eq("wrap_ovf", 64'(overflow), 64'h1);
      check_eq("wrap_oldest", 64'(rd_addr), 64'h100C);
      pulse_clear();

      // stop mode: first four held, then drain after disarm
      mode_stop = 1'b1;
      run(6);
      check_eq("stop_count", 64'(count), 64'h4);
      check_eq("stop_stopped", 64'(stopped), 64'h1);
      check_eq("stop_ovf", 64'(overflow), 64'h1);
      check_eq("stop_oldest", 64'(rd_addr), 64'h1004);
      arm = 1'b0;
      tick();
      check_eq("stop_disarm", 64'(stopped), 64'h0);
      rd_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_eq("drain_addr", 64'(rd_addr), 64'h1004 + 64'(4 * k));
         tick();
      end
      rd_ready = 1'b0;
      check_eq("drain_empty", 64'(rd_valid), 64'h0);
      pulse_clear();
      mode_stop = 1'b0; arm = 1'b1;
      tick();

      // error response on a read
      set_t(0, 32'h3000_0000, 1'b0, 32'h55AA_55AA, 1, 1'b1);
      run(1);
      check_eq("err_flag", 64'(rd_err), 64'h1);
      check_eq("err_data", 64'(rd_data), 64'h0);
      check_eq("err_addr", 64'(rd_addr), 64'h3000_0000);
      pulse_clear();

      // push and pop together on a full buffer
      for (int i = 0; i < 5; i++) set_t(i, 32'h1000 + 32'(4 * (i + 1)), 1'b1, 32'hB0 + 32'(i), 0, 1'b0);
      t_rdy[4] = 1'b1;
      run(5);
      check_eq("pp_count", 64'(count), 64'h4);
      check_eq("pp_ovf", 64'(overflow), 64'h0);
      check_eq("pp_head", 64'(rd_addr), 64'h1008);
      pulse_clear();

      // clear coincident with a push
      set_t(0, 32'h3000, 1'b1, 32'hC0, 0, 1'b0);
      t_clr[0] = 1'b1;
      run(1);
      check_eq("clr_push_count", 64'(count), 64'h0);
      tick();
      check_eq("clr_push_after", 64'(count), 64'h0);

      // asynchronous reset in the middle of a data phase
      set_t(0, 32'h5000, 1'b1, 32'hD0, 0, 1'b0);
      run(1);
      ahb.htrans = HTRANS_NONSEQ; ahb.haddr = 32'h5004; ahb.hwrite = 1'b1;
      ahb.hsize = HSIZE_WORD; ahb.hready = 1'b1;
      tick();
      ahb.htrans = HTRANS_IDLE; ahb.hready = 1'b0; ahb.hwdata = 32'hD1;
      tick();
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_count", 64'(count), 64'h0);
      check_eq("rst_mid_flags", 64'({rd_valid, overflow, stopped}), 64'h0);
      check_eq("rst_mid_rd", 64'({rd_addr, rd_data}), 64'h0);
      model_reset();
      tick();
      rst_n = 1'b1; ahb.hready = 1'b1;
      tick();
      check_eq("rst_mid_norec", 64'(count), 64'h0);
      tick();

      // randomized traffic and configuration
      rand_rdy = 1'b1;
      for (int b = 0; b < 150; b++) begin
         arm       = ($urandom_range(0, 7) != 0);
         mode_stop = 1'($urandom_range(0, 1));
         cap_r     = ($urandom_range(0, 3) != 0);
         cap_w     = ($urandom_range(0, 3) != 0);
         top       = 32'($urandom_range(2, 4));
         win_base  = top << 28;
         case ($urandom_range(0, 2))
            0:       win_mask = 32'h0;
            1:       win_mask = 32'hF000_0000;
            default: win_mask = 32'hF000_0004;
         endcase
         n = $urandom_range(1, MAXT);
         for (int i = 0; i < n; i++) begin
            top = 32'($urandom_range(2, 4));
            t_addr[i] = (top << 28) | ($urandom() & 32'h0FFF_FFFC);
            t_data[i] = $urandom();
            t_wr[i]   = 1'($urandom_range(0, 1));
            t_sz[i]   = 3'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
               0:       t_tr[i] = HTRANS_IDLE;
               1:       t_tr[i] = HTRANS_BUSY;
               2, 3, 4: t_tr[i] = HTRANS_SEQ;
               default: t_tr[i] = HTRANS_NONSEQ;
            endcase
            t_waits[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            t_err[i]   = ($urandom_range(0, 15) == 0);
            t_rdy[i]   = 1'b0;
            t_clr[i]   = ($urandom_range(0, 40) == 0);
         end
         run(n);
         if ($urandom_range(0, 3) == 0) begin
            rd_ready = 1'($urandom_range(0, 1));
            tick();
            rd_ready = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ahbl_trace_buffer.md
# ahbl_trace_buffer

Synthesisable AHB-Lite transfer tracer: passively snoops one master port (e.g. proc0) on clk_sys, filters completed transfers by address window and direction, and stores one record per transfer in a circular buffer. Records drain through a valid/ready readout port for a debug UART bridge or an on-chip trace reader. It replaces the bench-only `$display` bus monitor in hardware, adding depth, filtering, wrap and stop modes, and error capture.

## Interface
Parameters:
- W_ADDR, 32, snooped address width
- W_DATA, 32, snooped data width
- DEPTH, 64, record count; power of 2, ≥2
- W_CNT, $clog2(DEPTH)+1, derived; width of count

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- haddr  in  W_ADDR  snooped address
- htrans  in  2  snooped transfer type
- hwrite  in  1  snooped direction
- hsize  in  3  snooped size
- hready  in  1  snooped ready
- hresp  in  1  snooped error response
- hwdata  in  W_DATA  snooped write data
- hrdata  in  W_DATA  snooped read data
- arm  in  1  level; capture enable
- clear  in  1  pulse; flush buffer, clear overflow
- mode_stop  in  1  0 = wrap (overwrite oldest), 1 = stop when full
- cap_r, cap_w  in  1 each  enable capture of reads / writes
- win_base, win_mask  in  W_ADDR each  address filter
- rd_valid  out  1  record available
- rd_ready  in  1  consumer accepts record
- rd_addr  out  W_ADDR  record address
- rd_data  out  W_DATA  record data
- rd_write, rd_err  out  1 each  record direction / error flag
- rd_size  out  3  record size
- count  out  W_CNT  records held
- overflow  out  1  sticky: a record was lost or overwritten
- stopped  out  1  FSM in STOPPED

## Operation
- FSM: IDLE (reset) -> ARMED when arm=1; ARMED -> IDLE when arm=0; ARMED -> STOPPED when mode_stop=1 and count reaches DEPTH; STOPPED -> IDLE when arm=0. clear does not change state.
- Address phase sampled only on cycles with hready=1. Qualify: htrans[1]=1, state ARMED, (hwrite ? cap_w : cap_r), and ((haddr ^ win_base) & win_mask)==0. win_mask=0 passes everything. Store a dph_act flag plus addr/size/write.
- Data phase completes on the next hready=1 cycle. If dph_act is set, push a record: data = hwdata for writes, hrdata for reads; err = hresp; data forced to 0 when err=1. Wait states (hready=0) extend the data phase; nothing is sampled.
- Push when full: wrap mode overwrites the oldest record (read pointer advances) and sets overflow. Stop mode drops the record and sets overflow; the push that makes count = DEPTH causes the STOPPED transition.
- Pop: rd_valid && rd_ready advances the read pointer. With simultaneous push and pop when full, the pop is taken first, so nothing is overwritten, count is unchanged, and overflow is not set.
- clear: pointers and count go to 0 and overflow goes to 0; a coincident push is dropped; dph_act is cleared.
- An arm deassert during a data phase does not cancel a qualified transfer already in its data phase.
- Reset values: count=0, rd_valid=0, overflow=0, stopped=0, rd_* = 0, state IDLE, dph_act=0.

## Timing
- A record pushed at edge N is visible on rd_* with rd_valid=1 after edge N, i.e. in cycle N+1.
- rd_* are combinational from storage at the read pointer. rd_valid = (count != 0).
- Back-to-back zero-wait transfers sustain one push per cycle.
- count and overflow are registered and update on the push/pop edge.

## Structure
- Package ahbl_trace_pkg holds: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HSIZE encodings, FSM state enum, and the record field layout/width function of W_ADDR/W_DATA.
- Sub-module ahbl_trace_mem: DEPTH×record circular storage with write/read pointers, full/empty logic, overwrite-on-full option, and clear. The top level contains the snoop pipeline, filter and FSM.

## Test plan
- Armed, mask=0: write 0x20000004←0xDEADBEEF word, then read 0x20000008→0x12345678 with 2 wait states -> two records in order, rd_size=2, count=2, err=0.
- Window base=0x40000000, mask=0xF0000000: accesses to 0x40000010 and 0x20000000 -> only the 0x40000010 record is captured. With cap_r=0, reads are also excluded.
- DEPTH=4, wrap mode, 6 pushes with rd_ready=0 -> count=4, overflow=1, oldest record = push #3.
- DEPTH=4, stop mode, 6 pushes -> records #1–#4 held, stopped=1, overflow=1. Deassert arm -> IDLE; drain 4 records, then rd_valid=0.
- Error response (hresp=1, hready=0 then hresp=1, hready=1) on read 0x30000000 -> record err=1, data=0.
- Full buffer with push+pop on the same edge -> count stays 4, overflow stays 0. clear with a coincident push -> count=0. rst_n asserted mid data phase -> all outputs at reset values and no record afterwards.
